// File: rtl/jtag_pkg.sv
// jtag_pkg: shared state encoding and LENGTH width helper for the JTAG vector shifter
package jtag_pkg;

    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        TCKL = 4'b0010,
        TCKH = 4'b0100,
        RESP = 4'b1000
    } state_t;

    function automatic int len_w(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/jtag_tck_div.sv
// jtag_tck_div: one-cycle tick every h enabled cycles; counter clears while disabled
module jtag_tck_div #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         en,
    input  logic [W-1:0] h,
    output logic         tick
);

    logic [W-1:0] cnt;

    assign tick = en && cnt == h - 1'b1;

    always_ff @(posedge CLK) begin
        if (RESET || !en)
            cnt <= '0;
        else
            cnt <= tick ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/jtag_vector_shifter.sv
// jtag_vector_shifter: shifts up to C_VECTOR_WIDTH TMS/TDI bits out on a divided TCK and captures TDO
module jtag_vector_shifter import jtag_pkg::*; #(
    parameter int C_VECTOR_WIDTH = 32,
    parameter int C_DIV_WIDTH    = 8
) (
    input  logic                               CLK,
    input  logic                               RESET,
    input  logic                               CMD_VALID,
    output logic                               CMD_READY,
    input  logic [len_w(C_VECTOR_WIDTH)-1:0]   LENGTH,
    input  logic [C_VECTOR_WIDTH-1:0]          TMS_VECTOR,
    input  logic [C_VECTOR_WIDTH-1:0]          TDI_VECTOR,
    input  logic [C_DIV_WIDTH-1:0]             TCK_HALF,
    input  logic                               ABORT,
    output logic                               RSP_VALID,
    input  logic                               RSP_READY,
    output logic [C_VECTOR_WIDTH-1:0]          TDO_VECTOR,
    output logic                               ERROR,
    output logic                               BUSY,
    output logic                               TCK,
    output logic                               TMS,
    output logic                               TDI,
    input  logic                               TDO
);

    localparam int LW = len_w(C_VECTOR_WIDTH);
    localparam int IW = $clog2(C_VECTOR_WIDTH);

    state_t                    state;
    logic [C_VECTOR_WIDTH-1:0] tms_r, tdi_r;
    logic [LW-1:0]             len_r;
    logic [IW-1:0]             idx;
    logic [C_DIV_WIDTH-1:0]    h_r;
    logic                      tick, last, bad;

    assign BUSY = state != IDLE;
    assign last = LW'(idx) == len_r - 1'b1;
    assign bad  = LENGTH == '0 || LENGTH > LW'(C_VECTOR_WIDTH);

    jtag_tck_div #(.W(C_DIV_WIDTH)) u_div (
        .CLK   (CLK),
        .RESET (RESET),
        .en    (state == TCKL || state == TCKH),
        .h     (h_r),
        .tick  (tick)
    );

    // CMD_READY stays low for the first IDLE cycle after a response
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= IDLE;
            CMD_READY  <= 1'b0;
            RSP_VALID  <= 1'b0;
            ERROR      <= 1'b0;
            TDO_VECTOR <= '0;
            TCK        <= 1'b0;
            TMS        <= 1'b0;
            TDI        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (CMD_VALID && CMD_READY) begin
                        tms_r      <= TMS_VECTOR;
                        tdi_r      <= TDI_VECTOR;
                        len_r      <= LENGTH;
                        h_r        <= (TCK_HALF == '0) ? C_DIV_WIDTH'(1) : TCK_HALF;
                        idx        <= '0;
                        TDO_VECTOR <= '0;
                        CMD_READY  <= 1'b0;
                        if (bad) begin
                            state     <= RESP;
                            RSP_VALID <= 1'b1;
                            ERROR     <= 1'b1;
                        end else begin
                            state <= TCKL;
                            TMS   <= TMS_VECTOR[0];
                            TDI   <= TDI_VECTOR[0];
                        end
                    end else begin
                        CMD_READY <= 1'b1;
                    end
                end
                TCKL: begin
                    if (ABORT) begin
                        state     <= IDLE;
                        TCK       <= 1'b0;
                        CMD_READY <= 1'b1;
                    end else if (tick) begin
                        state           <= TCKH;
                        TCK             <= 1'b1;
                        TDO_VECTOR[idx] <= TDO;
                    end
                end
                TCKH: begin
                    if (ABORT) begin
                        state     <= IDLE;
                        TCK       <= 1'b0;
                        CMD_READY <= 1'b1;
                    end else if (tick) begin
                        TCK <= 1'b0;
                        if (last) begin
                            state     <= RESP;
                            RSP_VALID <= 1'b1;
                            ERROR     <= 1'b0;
                        end else begin
                            state <= TCKL;
                            idx   <= idx + 1'b1;
                            TMS   <= tms_r[idx + 1'b1];
                            TDI   <= tdi_r[idx + 1'b1];
                        end
                    end
                end
                RESP: begin
                    if (RSP_READY) begin
                        state     <= IDLE;
                        RSP_VALID <= 1'b0;
                        ERROR     <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_vector_shifter.sv
// tb_jtag_vector_shifter: table, random and corner-case checks of jtag_vector_shifter against a behavioural model
module tb_jtag_vector_shifter;

    localparam int W  = 32;
    localparam int DW = 8;
    localparam int LW = 6;

    logic          clk = 0, rst = 1;
    logic          cmd_valid = 0, cmd_ready;
    logic [LW-1:0] length = 0;
    logic [W-1:0]  tms_vec = 0, tdi_vec = 0;
    logic [DW-1:0] tck_half = 0;
    logic          abort = 0, rsp_valid, rsp_ready = 0;
    logic [W-1:0]  tdo_vec;
    logic          error, busy, tck, tms, tdi, tdo;

    int total = 0, bad = 0;
    int rises = 0, hi_cnt = 0, pat_base = 0, rb = 0, hb = 0;
    bit loop = 1;
    logic [W-1:0] pat = 0;
    bit cap_tms[$], cap_tdi[$];

    always #5 clk = ~clk;

    // TDO either loops back TDI or replays a pattern indexed by TCK rises of the current command
    assign tdo = loop ? tdi :
                 (rises - pat_base >= 0 && rises - pat_base < W) ? pat[rises - pat_base] : 1'b0;

    always @(posedge tck) begin
        rises <= rises + 1;
        cap_tms.push_back(tms);
        cap_tdi.push_back(tdi);
    end

    always @(posedge clk) if (tck) hi_cnt <= hi_cnt + 1;

    jtag_vector_shifter #(.C_VECTOR_WIDTH(W), .C_DIV_WIDTH(DW)) dut (
        .CLK(clk), .RESET(rst), .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready),
        .LENGTH(length), .TMS_VECTOR(tms_vec), .TDI_VECTOR(tdi_vec), .TCK_HALF(tck_half),
        .ABORT(abort), .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .TDO_VECTOR(tdo_vec),
        .ERROR(error), .BUSY(busy), .TCK(tck), .TMS(tms), .TDI(tdi), .TDO(tdo)
    );

    typedef struct {
        int         len;
        logic [31:0] tms;
        logic [31:0] tdi;
        int         half;
        int         lat;
        bit         err;
        logic [31:0] tdo;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mask_of(input int len);
        return (len >= 32) ? 32'hFFFF_FFFF : (32'h1 << len) - 32'h1;
    endfunction

    task automatic start_cmd(input int len, input logic [31:0] tm, input logic [31:0] td, input int half);
        length    = LW'(len);
        tms_vec   = tm;
        tdi_vec   = td;
        tck_half  = DW'(half);
        cmd_valid = 1;
        for (int k = 0; k < 20 && !cmd_ready; k++) @(negedge clk);
        chk("accept_wait", cmd_ready, 1);
        rb = rises;
        hb = hi_cnt;
        pat_base = rises;
        @(negedge clk);
        cmd_valid = 0;
        tms_vec   = $urandom;
        tdi_vec   = $urandom;
        tck_half  = DW'($urandom);
        length    = LW'($urandom);
    endtask

    task automatic finish_cmd(input string nm, input int exp_lat, input bit exp_err, input logic [31:0] exp_tdo,
                              input int len, input int h, input logic [31:0] tm, input logic [31:0] td, input bit ack);
        int n, nr;
        logic [31:0] cm, cd;
        n = 1;
        while (!rsp_valid && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_lat"}, n, exp_lat);
        chk({nm, "_err"}, error, exp_err);
        chk({nm, "_tdo"}, tdo_vec, exp_tdo);
        nr = exp_err ? 0 : len;
        chk({nm, "_rises"}, rises - rb, nr);
        chk({nm, "_hicyc"}, hi_cnt - hb, nr * h);
        if (!exp_err) begin
            cm = 0;
            cd = 0;
            for (int i = 0; i < len; i++)
                if (rb + i < cap_tms.size()) begin
                    cm[i] = cap_tms[rb + i];
                    cd[i] = cap_tdi[rb + i];
                end
            chk({nm, "_tms_bits"}, cm, tm & mask_of(len));
            chk({nm, "_tdi_bits"}, cd, td & mask_of(len));
            chk({nm, "_tms_hold"}, tms, tm[len - 1]);
        end
        if (ack) begin
            rsp_ready = 1;
            @(negedge clk);
            rsp_ready = 0;
            chk({nm, "_rsp_drop"}, rsp_valid, 0);
        end
    endtask

    task automatic run_model(input string nm, input int len, input logic [31:0] tm, input logic [31:0] td,
                             input int half, input bit lp, input logic [31:0] pt);
        int h, lat;
        bit err;
        logic [31:0] exp_tdo;
        loop = lp;
        pat  = pt;
        h    = (half == 0) ? 1 : half;
        err  = (len == 0 || len > W);
        lat  = err ? 1 : 2 * h * len + 1;
        exp_tdo = err ? 32'h0 : ((lp ? td : pt) & mask_of(len));
        start_cmd(len, tm, td, half);
        finish_cmd(nm, lat, err, exp_tdo, len, h, tm, td, 1);
    endtask

    initial begin
        bit rv;
        tbl[0] = '{5,  32'h0000_001F, 32'h0000_000A, 2, 21, 1'b0, 32'h0000_000A};
        tbl[1] = '{32, 32'h3C3C_0FF0, 32'hA5A5_A5A5, 0, 65, 1'b0, 32'hA5A5_A5A5};
        tbl[2] = '{0,  32'h0000_000F, 32'h0000_000F, 1, 1,  1'b1, 32'h0000_0000};
        tbl[3] = '{33, 32'h0000_000F, 32'h0000_000F, 1, 1,  1'b1, 32'h0000_0000};
        tbl[4] = '{1,  32'h0000_0001, 32'h0000_0001, 1, 3,  1'b0, 32'h0000_0001};
        tbl[5] = '{3,  32'h0000_0005, 32'h0000_00FF, 3, 19, 1'b0, 32'h0000_0007};
        tbl[6] = '{8,  32'h0000_0081, 32'h0000_005A, 1, 17, 1'b0, 32'h0000_005A};

        repeat (3) @(negedge clk);
        chk("reset_state", {tck, tms, tdi, rsp_valid, error, busy, cmd_ready, tdo_vec}, 0);
        rst = 0;
        @(negedge clk);
        chk("ready_after_reset", cmd_ready, 1);

        loop = 1;
        for (int t = 0; t < 7; t++) begin
            start_cmd(tbl[t].len, tbl[t].tms, tbl[t].tdi, tbl[t].half);
            finish_cmd($sformatf("tbl%0d", t), tbl[t].lat, tbl[t].err, tbl[t].tdo, tbl[t].len,
                       tbl[t].half == 0 ? 1 : tbl[t].half, tbl[t].tms, tbl[t].tdi, 1);
        end

        for (int r = 0; r < 25; r++) begin
            int len;
            len = ($urandom_range(0, 9) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : $urandom_range(33, 63))
                                              : $urandom_range(1, 32);
            run_model($sformatf("rnd%0d", r), len, $urandom, $urandom, $urandom_range(0, 3),
                      bit'($urandom_range(0, 1)), $urandom);
        end

        // backpressure: response held, ABORT in RESP ignored, new command waits
        loop = 1;
        start_cmd(4, 32'hF, 32'h9, 1);
        finish_cmd("hold", 9, 0, 32'h9, 4, 1, 32'hF, 32'h9, 0);
        length = 4; tms_vec = 32'h3; tdi_vec = 32'h6; tck_half = 1; cmd_valid = 1; abort = 1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            abort = 0;
            chk("hold_stable", {rsp_valid, error, cmd_ready, tdo_vec}, {1'b1, 1'b0, 1'b0, 32'h9});
        end
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        chk("ack_gap", {rsp_valid, cmd_ready}, 0);
        @(negedge clk);
        chk("ready_again", cmd_ready, 1);
        rb = rises; hb = hi_cnt; pat_base = rises;
        @(negedge clk);
        cmd_valid = 0;
        chk("second_accept", busy, 1);
        finish_cmd("hold_next", 9, 0, 32'h6, 4, 1, 32'h3, 32'h6, 1);

        // abort during the third of eight bits
        start_cmd(8, 32'hAA, 32'h3C, 2);
        repeat (8) @(negedge clk);
        chk("abort_pre", {busy, tck}, {1'b1, 1'b0});
        abort = 1;
        @(negedge clk);
        abort = 0;
        chk("abort_state", {tck, busy, rsp_valid, cmd_ready}, {1'b0, 1'b0, 1'b0, 1'b1});
        rv = 0;
        repeat (30) begin
            @(negedge clk);
            rv |= rsp_valid;
        end
        chk("abort_no_rsp", rv, 0);
        run_model("after_abort", 6, 32'h15, 32'h2B, 1, 1, 32'h0);

        // reset mid-transfer
        start_cmd(8, 32'hFF, 32'hFF, 2);
        repeat (7) @(negedge clk);
        rst = 1;
        @(negedge clk);
        chk("rst_mid", {tck, tms, tdi, rsp_valid, error, busy, cmd_ready, tdo_vec}, 0);
        rst = 0;
        @(negedge clk);
        chk("rst_release", {cmd_ready, busy, rsp_valid}, 3'b100);
        run_model("after_reset", 7, 32'h55, 32'h33, 2, 0, 32'h6C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/jtag_vector_shifter.md
JTAG_VECTOR_SHIFTER -- requirements
Module: jtag_vector_shifter

Interface
REQ-001 SHALL have parameter C_VECTOR_WIDTH, default 32; max bits per command, range 2..256.
REQ-002 SHALL have parameter C_DIV_WIDTH, default 8; width of the runtime TCK half-period input.
REQ-003 SHALL have port CLK  in  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port RESET  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port CMD_VALID  in  1  command offered.
REQ-006 SHALL have port CMD_READY  out  1  command accepted when CMD_VALID and CMD_READY are both high.
REQ-007 SHALL have port LENGTH  in  clog2(C_VECTOR_WIDTH)+1  bits to shift.
REQ-008 SHALL have port TMS_VECTOR  in  C_VECTOR_WIDTH  TMS bits, bit 0 first.
REQ-009 SHALL have port TDI_VECTOR  in  C_VECTOR_WIDTH  TDI bits, bit 0 first.
REQ-010 SHALL have port TCK_HALF  in  C_DIV_WIDTH  CLK cycles per TCK half-period; 0 treated as 1.
REQ-011 SHALL have port ABORT  in  1  cancel the command in flight.
REQ-012 SHALL have port RSP_VALID  out  1  result available.
REQ-013 SHALL have port RSP_READY  in  1  result consumed.
REQ-014 SHALL have port TDO_VECTOR  out  C_VECTOR_WIDTH  captured TDO; bit i is the TDO value for shifted bit i.
REQ-015 SHALL have port ERROR  out  1  command rejected; valid while RSP_VALID is high.
REQ-016 SHALL have port BUSY  out  1  high whenever the state is not IDLE.
REQ-017 SHALL have ports TCK, TMS, TDI  out  1 each, and TDO  in  1; all registered, no tristate.

Function
REQ-018 SHALL implement states IDLE, TCKL, TCKH, RESP.
REQ-019 SHALL assert CMD_READY only in IDLE.
REQ-020 SHALL, on accept, latch TMS_VECTOR, TDI_VECTOR, LENGTH and H=max(TCK_HALF,1), clear TDO_VECTOR, and go to TCKL.
REQ-021 SHALL treat LENGTH==0 or LENGTH>C_VECTOR_WIDTH as an error: go directly to RESP with ERROR=1 and TDO_VECTOR=0, with no TCK edges.
REQ-022 SHALL, in TCKL for bit i, drive TCK=0 and TMS/TDI=bit i for H cycles, then raise TCK and enter TCKH.
REQ-023 SHALL sample TDO into TDO_VECTOR[i] on the CLK edge that raises TCK.
REQ-024 SHALL, in TCKH, hold TCK=1 for H cycles, then lower TCK and either advance to bit i+1 in TCKL or, after the last bit, enter RESP.
REQ-025 SHALL assert RSP_VALID exactly 2*H*LENGTH+1 CLK cycles after the accepting edge.
REQ-026 SHALL keep TDO_VECTOR bits at index >= LENGTH at 0.
REQ-027 SHALL, in RESP, hold RSP_VALID, TDO_VECTOR and ERROR stable until RSP_READY is high, then return to IDLE on the next edge.
REQ-028 SHALL NOT accept a new command in the RESP-to-IDLE cycle; accept is possible one cycle later at the earliest.
REQ-029 SHALL hold TMS and TDI at the last shifted bit value after completion until the next command starts.
REQ-030 SHALL ignore changes to TCK_HALF or the input vectors while BUSY is high.
REQ-031 SHALL, on ABORT in TCKL or TCKH, go to IDLE next edge with TCK=0 and produce no response.
REQ-032 SHALL ignore ABORT in IDLE and in RESP.
REQ-033 SHALL give ABORT priority over a simultaneous TCK edge.
REQ-034 SHALL use a half-period counter of C_DIV_WIDTH bits that wraps only on terminal count H-1.

Reset
REQ-035 SHALL, while RESET is high, force state IDLE and TCK=TMS=TDI=0, RSP_VALID=0, ERROR=0, BUSY=0, CMD_READY=0, TDO_VECTOR=0.
REQ-036 SHALL drive CMD_READY=1 on the first cycle after RESET deasserts.
REQ-037 SHALL, on RESET mid-transfer, discard the transfer without a response; reset wins over every other input.

Structure
REQ-038 SHALL take the state encoding (one-hot, 4 bits) and the LENGTH-width function from shared package jtag_pkg.
REQ-039 SHALL contain one sub-module, jtag_tck_div, which produces a one-cycle tick every H cycles when enabled and clears when disabled.

Verification
REQ-040 SHALL cover: LENGTH=5, TCK_HALF=2, TMS=0x1F, TDI=0x0A, TDO looped back from TDI -> 5 TCK pulses of 4 CLK each, TDO_VECTOR=0x0A, RSP_VALID at cycle 21.
REQ-041 SHALL cover: LENGTH=C_VECTOR_WIDTH, TCK_HALF=0, TDI=0xA5A5A5A5 looped back -> period 2 CLK, TDO_VECTOR=0xA5A5A5A5, ERROR=0.
REQ-042 SHALL cover: LENGTH=0, then LENGTH=33 at width 32 -> no TCK edges, RSP_VALID at cycle 1, ERROR=1, TDO_VECTOR=0.
REQ-043 SHALL cover: RSP_READY held low for 10 cycles with CMD_VALID high -> response stable, CMD_READY=0, next accept at the second cycle after RSP_READY.
REQ-044 SHALL cover: ABORT during the 3rd bit of 8 -> TCK=0 next cycle, no RSP_VALID, next command completes normally.
REQ-045 SHALL cover: RESET pulse mid-transfer -> all outputs at reset values the following cycle, CMD_READY=1 after release.
